// File: rtl/colorclk_ctrl.sv
// Colour-clock DDS increment controller: qualifies {altern,mode} requests, loads the new increment on an
// accumulator wrap (or timeout), then settles before reporting lock. Define COLORCLK_PHASE_RESET_EN for frame-start phase reset.
module colorclk_ctrl #(
    parameter int STABLE_CYCLES = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int ALIGN_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        altern,
    input  logic        acc_msb,
    input  logic        frame_start,
    output logic [28:0] prescaler,
    output logic        acc_clear,
    output logic        busy,
    output logic        locked,
    output logic        cur_mode,
    output logic        cur_altern
);

    localparam int MAX_A = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
    localparam int MAX_P = (ALIGN_TIMEOUT > MAX_A) ? ALIGN_TIMEOUT : MAX_A;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST  = CNT_W'(ALIGN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        LOCKED = 3'd1,
        QUAL   = 3'd2,
        ALIGN  = 3'd3,
        LOAD   = 3'd4
    } state_t;

    function automatic logic [28:0] incr_lookup(input logic [1:0] sel);
        logic [28:0] v;
        case (sel)
            2'b00:   v = 29'd79342698;
            2'b01:   v = 29'd64058453;
            2'b10:   v = 29'd56006610;
            2'b11:   v = 29'd45217732;
            default: v = 29'd79342698;
        endcase
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + CNT_ONE;
        end
        return r;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        cand_r;
    logic [1:0]        cur_r;
    logic [28:0]       prescaler_r;
    logic              msb_prev_r;
    logic              busy_r;
    logic              locked_r;
    logic [1:0]        req_s;
    logic              fell_s;

    assign req_s  = {altern, mode};
    assign fell_s = msb_prev_r & ~acc_msb;

    // Control FSM: qualification, wrap alignment, increment load and settle timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SETTLE;
            cnt_r       <= CNT_ZERO;
            cand_r      <= 2'b00;
            cur_r       <= 2'b00;
            prescaler_r <= incr_lookup(2'b00);
            msb_prev_r  <= 1'b0;
            busy_r      <= 1'b1;
            locked_r    <= 1'b0;
        end else begin
            msb_prev_r <= acc_msb;
            case (state_r)
                SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_r  <= LOCKED;
                        cnt_r    <= CNT_ZERO;
                        busy_r   <= 1'b0;
                        locked_r <= 1'b1;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                LOCKED: begin
                    if (req_s != cur_r) begin
                        cand_r   <= req_s;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= QUAL;
                        busy_r   <= 1'b1;
                        locked_r <= 1'b0;
                    end
                end
                QUAL: begin
                    if (req_s == cand_r) begin
                        if (cnt_r == STABLE_LAST) begin
                            state_r <= ALIGN;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end else if (req_s == cur_r) begin
                        // request withdrawn: nothing was applied, so simply resume lock
                        state_r  <= LOCKED;
                        cnt_r    <= CNT_ZERO;
                        busy_r   <= 1'b0;
                        locked_r <= 1'b1;
                    end else begin
                        cand_r <= req_s;
                        cnt_r  <= CNT_ZERO;
                    end
                end
                ALIGN: begin
                    if (fell_s || (cnt_r == ALIGN_LAST)) begin
                        state_r <= LOAD;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                LOAD: begin
                    prescaler_r <= incr_lookup(cand_r);
                    cur_r       <= cand_r;
                    state_r     <= SETTLE;
                    cnt_r       <= CNT_ZERO;
                end
                default: begin
                    state_r  <= SETTLE;
                    cnt_r    <= CNT_ZERO;
                    busy_r   <= 1'b1;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef COLORCLK_PHASE_RESET_EN
    logic acc_clear_r;

    // One-cycle accumulator clear following a frame start seen while locked; never queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_clear_r <= 1'b0;
        end else begin
            acc_clear_r <= frame_start & (state_r == LOCKED);
        end
    end

    assign acc_clear = acc_clear_r;
`else
    logic unused_frame_start_s;

    assign unused_frame_start_s = frame_start;
    assign acc_clear            = 1'b0;
`endif

    assign prescaler  = prescaler_r;
    assign busy       = busy_r;
    assign locked     = locked_r;
    assign cur_mode   = cur_r[0];
    assign cur_altern = cur_r[1];

endmodule

// File: tb/tb_colorclk_ctrl.sv
// Randomised bench for colorclk_ctrl: a DDS accumulator drives acc_msb and a behavioural model is compared every cycle.
module tb_colorclk_ctrl;

    localparam int STABLE = 16;
    localparam int SETTLE = 1024;
    localparam int ATO    = 64;

    logic        clk = 1'b0;
    logic        rst, mode, altern, acc_msb, frame_start;
    logic [28:0] prescaler;
    logic        acc_clear, busy, locked, cur_mode, cur_altern;

    colorclk_ctrl #(
        .STABLE_CYCLES(STABLE),
        .SETTLE_CYCLES(SETTLE),
        .ALIGN_TIMEOUT(ATO)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .altern(altern), .acc_msb(acc_msb),
        .frame_start(frame_start), .prescaler(prescaler), .acc_clear(acc_clear),
        .busy(busy), .locked(locked), .cur_mode(cur_mode), .cur_altern(cur_altern)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit stopped = 1'b0;

    logic [28:0] incr_tab [4] = '{29'd79342698, 29'd64058453, 29'd56006610, 29'd45217732};

    // DDS accumulator driving acc_msb
    logic [28:0] acc;
    bit          force_low;

    // behavioural model: what is applied, and how much of each waiting period is left
    logic [1:0]  m_cur, m_cand;
    logic [28:0] m_pres;
    int          settle_left, run, align_age;
    bit          qualifying, aligning, load_now, prev_msb, m_clear, phase_reset_en;

    task automatic finish_run();
        if (!stopped) begin
            stopped = 1'b1;
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    endtask

    task automatic cmp(input string nm, input logic [28:0] act, input logic [28:0] exp);
        if (!stopped && (act !== exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
            if (miscompares >= 40) finish_run();
        end
    endtask

    task automatic check_lit(input string nm, input int act, input int exp);
        vectors++;
        if (!stopped && (act != exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
            if (miscompares >= 40) finish_run();
        end
    endtask

    task automatic model_reset();
        m_cur = 2'b00; m_cand = 2'b00; m_pres = incr_tab[0];
        settle_left = SETTLE; run = 0; align_age = 0;
        qualifying = 1'b0; aligning = 1'b0; load_now = 1'b0; prev_msb = 1'b0; m_clear = 1'b0;
    endtask

    function automatic bit m_locked();
        return !(load_now || (settle_left > 0) || aligning || qualifying);
    endfunction

    task automatic model_step(input logic [1:0] req, input logic msb, input logic fs);
        m_clear = 1'b0;
        if (load_now) begin
            m_pres = incr_tab[m_cand];
            m_cur = m_cand;
            load_now = 1'b0;
            settle_left = SETTLE;
        end else if (settle_left > 0) begin
            settle_left--;
        end else if (aligning) begin
            align_age++;
            if ((prev_msb && !msb) || (align_age == ATO)) begin
                aligning = 1'b0;
                load_now = 1'b1;
            end
        end else if (qualifying) begin
            if (req == m_cand) begin
                run++;
                if (run == STABLE) begin
                    qualifying = 1'b0;
                    aligning = 1'b1;
                    align_age = 0;
                end
            end else if (req == m_cur) begin
                qualifying = 1'b0;
            end else begin
                m_cand = req;
                run = 0;
            end
        end else begin
            if (phase_reset_en) m_clear = fs;
            if (req != m_cur) begin
                m_cand = req;
                run = 0;
                qualifying = 1'b1;
            end
        end
        prev_msb = msb;
    endtask

    task automatic tick();
        logic [1:0]  req;
        logic        msb, fs, r;
        logic [28:0] pres_before;
        bit          clr_before;
        @(posedge clk);
        req = {altern, mode}; msb = acc_msb; fs = frame_start; r = rst;
        pres_before = m_pres; clr_before = m_clear;
        #1;
        if (r) model_reset();
        else model_step(req, msb, fs);
        acc = clr_before ? 29'd0 : acc + pres_before;
        acc_msb = force_low ? 1'b0 : acc[28];
        vectors++;
        cmp("prescaler", prescaler, m_pres);
        cmp("acc_clear", {28'd0, acc_clear}, {28'd0, m_clear});
        cmp("busy", {28'd0, busy}, {28'd0, !m_locked()});
        cmp("locked", {28'd0, locked}, {28'd0, m_locked()});
        cmp("cur_mode", {28'd0, cur_mode}, {28'd0, m_cur[0]});
        cmp("cur_altern", {28'd0, cur_altern}, {28'd0, m_cur[1]});
    endtask

    task automatic wait_pres_change(input logic [28:0] old, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((prescaler === old) && (n < 400));
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((locked !== 1'b1) && (n < 2000));
    endtask

    task automatic check_reset_values(input string tag);
        check_lit({tag, "_prescaler"}, int'(prescaler), 79342698);
        check_lit({tag, "_busy"}, int'(busy), 1);
        check_lit({tag, "_locked"}, int'(locked), 0);
        check_lit({tag, "_acc_clear"}, int'(acc_clear), 0);
        check_lit({tag, "_cur"}, int'({cur_altern, cur_mode}), 0);
    endtask

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
        finish_run();
    end

    initial begin
        int n;
        int cyc;
        int hold;
`ifdef COLORCLK_PHASE_RESET_EN
        phase_reset_en = 1'b1;
`else
        phase_reset_en = 1'b0;
`endif
        rst = 1'b1; mode = 1'b0; altern = 1'b0; acc_msb = 1'b0; frame_start = 1'b0;
        force_low = 1'b0; acc = 29'($urandom);
        model_reset();

        // reset, then settle at 00; a frame start during settle is ignored
        tick(); tick();
        check_reset_values("reset");
        rst = 1'b0;
        repeat (100) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check_lit("fs_in_settle", int'(acc_clear), 0);
        wait_locked(n);
        check_lit("settle_len", n + 101, 1024);

        // frame start while locked
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check_lit("fs_in_locked", int'(acc_clear), phase_reset_en ? 1 : 0);
        tick();
        check_lit("fs_pulse_width", int'(acc_clear), 0);

        // 00 -> 01 held, DDS running
        mode = 1'b1;
        wait_pres_change(29'd79342698, n);
        check_lit("ntsc_latency_ok", int'((n >= 18) && (n <= 82)), 1);
        check_lit("ntsc_prescaler", int'(prescaler), 64058453);
        wait_locked(n);
        check_lit("ntsc_settle_len", n, 1024);

        // short glitch back to 00 is rejected
        mode = 1'b0;
        repeat (5) tick();
        mode = 1'b1;
        repeat (30) tick();
        check_lit("glitch_prescaler", int'(prescaler), 64058453);
        check_lit("glitch_locked", int'(locked), 1);

        // acc_msb stuck low, request 11: load by timeout
        force_low = 1'b1; acc_msb = 1'b0;
        tick(); tick();
        altern = 1'b1; mode = 1'b1;
        wait_pres_change(29'd64058453, n);
        check_lit("timeout_latency", n, 82);
        check_lit("timeout_prescaler", int'(prescaler), 45217732);
        wait_locked(n);
        check_lit("timeout_settle_len", n, 1024);

        // reset during ALIGN while moving to 10, then the live request is applied
        mode = 1'b0;
        repeat (30) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_values("midreset");
        force_low = 1'b0;
        repeat (2200) tick();
        check_lit("post_reset_prescaler", int'(prescaler), 56006610);
        check_lit("post_reset_locked", int'(locked), 1);

        // randomised requests, glitches, stuck DDS, frame starts and occasional resets
        cyc = 0;
        while (cyc < 20000) begin
            mode = 1'($urandom_range(0, 1));
            altern = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) hold = $urandom_range(1, 25);
            else hold = $urandom_range(30, 1400);
            force_low = ($urandom_range(0, 5) == 0);
            if (force_low) acc_msb = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0; cyc++;
            end
            for (int i = 0; i < hold; i++) begin
                frame_start = ($urandom_range(0, 7) == 0);
                tick();
                cyc++;
            end
            frame_start = 1'b0;
        end

        finish_run();
    end

endmodule
